// File: rtl/dmem_mmio_responder_pkg.sv
// Shared decode constants, STATUS bit positions and MMIO FSM encoding for the
// data-memory responder.
package dmem_mmio_responder_pkg;

    localparam logic [23:0] MMIO_BASE    = 24'hFFFFFF;

    localparam logic [7:0]  OFF_STATUS   = 8'h00;
    localparam logic [7:0]  OFF_FEED_CMD = 8'h04;
    localparam logic [7:0]  OFF_SENSOR   = 8'h08;
    localparam logic [7:0]  OFF_TICKS    = 8'h0C;
    localparam logic [7:0]  OFF_CMP      = 8'h10;

    localparam int ST_FEED_ACTIVE = 0;
    localparam int ST_DONE        = 1;
    localparam int ST_ERR         = 2;
    localparam int ST_ALARM       = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } mmio_state_e;

    function automatic logic [31:0] status_word(input logic feed_active,
                                                input logic done,
                                                input logic err,
                                                input logic alarm);
        logic [31:0] w;
        w                 = '0;
        w[ST_FEED_ACTIVE] = feed_active;
        w[ST_DONE]        = done;
        w[ST_ERR]         = err;
        w[ST_ALARM]       = alarm;
        return w;
    endfunction

endpackage

// File: rtl/dmem_mmio_responder_timer.sv
// Millisecond tick timer: prescaler, 32-bit TICKS counter and CMP register.
// alarm_pulse is high in the cycle whose edge increments TICKS onto CMP.
module mmio_tick_timer
    import dmem_mmio_responder_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ticks_load,
    input  logic        cmp_load,
    input  logic [31:0] wdata,
    output logic [31:0] ticks,
    output logic [31:0] cmp,
    output logic        alarm_pulse
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   ticks_q, ticks_d;
    logic [31:0]   cmp_q,   cmp_d;
    logic          wrap;

    always_comb begin
        presc_d     = presc_q;
        ticks_d     = ticks_q;
        cmp_d       = cmp_load ? wdata : cmp_q;
        alarm_pulse = 1'b0;
        wrap        = (presc_q == PW'(PRESCALE - 1));
        // A TICKS load restarts the millisecond and suppresses that cycle's increment.
        if (ticks_load) begin
            ticks_d = wdata;
            presc_d = '0;
        end else if (wrap) begin
            presc_d     = '0;
            ticks_d     = ticks_q + 32'd1;
            alarm_pulse = (cmp_q != 32'd0) && (ticks_q + 32'd1 == cmp_q);
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            ticks_q <= '0;
            cmp_q   <= '0;
        end else begin
            presc_q <= presc_d;
            ticks_q <= ticks_d;
            cmp_q   <= cmp_d;
        end
    end

    assign ticks = ticks_q;
    assign cmp   = cmp_q;

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory port responder: combinational RAM passthrough plus a wait-stated
// MMIO window hosting the pet-feeder control registers.
module dmem_mmio_responder
    import dmem_mmio_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int PRESCALE    = 50000,
    parameter int RAM_AW      = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       address_dmem,
    input  logic [31:0]       data,
    input  logic              wren,
    output logic [31:0]       q_dmem,
    output logic              cpuStall,
    output logic [RAM_AW-1:0] ram_address,
    output logic [31:0]       ram_data,
    output logic              ram_wren,
    input  logic [31:0]       ram_q,
    output logic              feed_active,
    output logic [7:0]        feed_amount,
    input  logic              feed_done,
    input  logic [11:0]       sensor_level
);

    mmio_state_e state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        feed_active_q, feed_active_d;
    logic [7:0]  feed_amount_q, feed_amount_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        alarm_q, alarm_d;
    logic [11:0] sensor_q;

    logic        ram_sel, mmio_sel;
    logic [7:0]  offset;
    logic        wr_commit, rd_commit;
    logic [31:0] read_mux;
    logic [31:0] ticks, cmp;
    logic        alarm_pulse;

    assign ram_sel   = (address_dmem[31:RAM_AW] == '0);
    assign mmio_sel  = (address_dmem[31:8] == MMIO_BASE);
    assign offset    = address_dmem[7:0];

    // Side effects land only on the RESP->IDLE edge, so a stalled access commits once.
    assign wr_commit = (state_q == S_RESP) && mmio_sel && wren;
    assign rd_commit = (state_q == S_RESP) && mmio_sel && !wren;

    mmio_tick_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clock       (clock),
        .reset       (reset),
        .ticks_load  (wr_commit && (offset == OFF_TICKS)),
        .cmp_load    (wr_commit && (offset == OFF_CMP)),
        .wdata       (data),
        .ticks       (ticks),
        .cmp         (cmp),
        .alarm_pulse (alarm_pulse)
    );

    always_comb begin
        case (offset)
            OFF_STATUS: read_mux = status_word(feed_active_q, done_q, err_q, alarm_q);
            OFF_SENSOR: read_mux = {20'd0, sensor_q};
            OFF_TICKS:  read_mux = ticks;
            OFF_CMP:    read_mux = cmp;
            default:    read_mux = 32'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rdata_d    = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (mmio_sel) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 4'(WAIT_CYCLES - 1);
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    rdata_d = read_mux;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        feed_active_d = feed_active_q;
        feed_amount_d = feed_amount_q;
        done_d        = done_q;
        err_d         = err_q;
        alarm_d       = alarm_q;
        if (rd_commit && (offset == OFF_STATUS)) begin
            done_d  = 1'b0;
            err_d   = 1'b0;
            alarm_d = 1'b0;
        end
        if (wr_commit && (offset == OFF_FEED_CMD)) begin
            if (feed_active_q) begin
                err_d = 1'b1;
            end else if (data[7:0] != 8'd0) begin
                feed_active_d = 1'b1;
                feed_amount_d = data[7:0];
            end
        end
        // Set events follow the clear so they win when both hit the same edge.
        if (feed_done && feed_active_q) begin
            feed_active_d = 1'b0;
            done_d        = 1'b1;
        end
        if (alarm_pulse) begin
            alarm_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            rdata_q       <= '0;
            feed_active_q <= 1'b0;
            feed_amount_q <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            alarm_q       <= 1'b0;
            sensor_q      <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            rdata_q       <= rdata_d;
            feed_active_q <= feed_active_d;
            feed_amount_q <= feed_amount_d;
            done_q        <= done_d;
            err_q         <= err_d;
            alarm_q       <= alarm_d;
            sensor_q      <= sensor_level;
        end
    end

    assign ram_address = address_dmem[RAM_AW-1:0];
    assign ram_data    = data;
    assign ram_wren    = wren && ram_sel;
    assign cpuStall    = reset && mmio_sel && (state_q != S_RESP);
    assign feed_active = feed_active_q;
    assign feed_amount = feed_amount_q;

    always_comb begin
        if (ram_sel) begin
            q_dmem = ram_q;
        end else if (mmio_sel && (state_q == S_RESP)) begin
            q_dmem = rdata_q;
        end else begin
            q_dmem = 32'd0;
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: a transaction-level model predicts
// stall/read data every cycle, and literal expectations pin the key scenarios.
module tb_dmem_mmio_responder;

    localparam int          W         = 2;
    localparam int          PRESCALE  = 4;
    localparam int          RAM_AW    = 12;
    localparam logic [31:0] IDLE_ADDR = 32'h8000_0000;

    logic              clock;
    logic              reset;
    logic [31:0]       address_dmem;
    logic [31:0]       data;
    logic              wren;
    logic [31:0]       q_dmem;
    logic              cpuStall;
    logic [RAM_AW-1:0] ram_address;
    logic [31:0]       ram_data;
    logic              ram_wren;
    logic [31:0]       ram_q;
    logic              feed_active;
    logic [7:0]        feed_amount;
    logic              feed_done;
    logic [11:0]       sensor_level;

    int total = 0;
    int bad   = 0;

    dmem_mmio_responder #(.WAIT_CYCLES(W), .PRESCALE(PRESCALE), .RAM_AW(RAM_AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .cpuStall     (cpuStall),
        .ram_address  (ram_address),
        .ram_data     (ram_data),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q),
        .feed_active  (feed_active),
        .feed_amount  (feed_amount),
        .feed_done    (feed_done),
        .sensor_level (sensor_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Bench-side data RAM with asynchronous read.
    logic [31:0] tb_mem [0:(1<<RAM_AW)-1];
    always @(posedge clock) if (ram_wren) tb_mem[ram_address] <= ram_data;
    assign ram_q = tb_mem[ram_address];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_mmio(input logic [31:0] a);
        return a[31:8] == 24'hFFFFFF;
    endfunction

    function automatic logic is_ram(input logic [31:0] a);
        return a[31:RAM_AW] == '0;
    endfunction

    // ---------------- behavioural model ----------------
    // m_k: cycles spent on the current MMIO access (0 = first cycle presented,
    // W+1 = response cycle). Registers follow the register-map rules directly.
    int          m_k;
    int          m_since;
    logic [31:0] m_rd, m_ticks, m_cmp;
    logic        m_feed_active, m_done, m_err, m_alarm;
    logic [7:0]  m_feed_amount;
    logic [11:0] m_sensor;

    function automatic logic [31:0] model_read(input logic [7:0] off);
        case (off)
            8'h00:   return {28'd0, m_alarm, m_err, m_done, m_feed_active};
            8'h08:   return {20'd0, m_sensor};
            8'h0C:   return m_ticks;
            8'h10:   return m_cmp;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_k <= 0; m_since <= 0; m_rd <= '0; m_ticks <= '0; m_cmp <= '0;
            m_feed_active <= 1'b0; m_feed_amount <= '0;
            m_done <= 1'b0; m_err <= 1'b0; m_alarm <= 1'b0; m_sensor <= '0;
        end else begin
            m_sensor <= sensor_level;
            if (m_k == W + 1) begin
                m_k <= 0;
                if (is_mmio(address_dmem)) begin
                    if (!wren && address_dmem[7:0] == 8'h00) begin
                        m_done <= 1'b0; m_err <= 1'b0; m_alarm <= 1'b0;
                    end
                    if (wren && address_dmem[7:0] == 8'h04) begin
                        if (m_feed_active) m_err <= 1'b1;
                        else if (data[7:0] != 8'd0) begin
                            m_feed_active <= 1'b1;
                            m_feed_amount <= data[7:0];
                        end
                    end
                    if (wren && address_dmem[7:0] == 8'h10) m_cmp <= data;
                end
            end else if (is_mmio(address_dmem)) begin
                if (m_k == W) m_rd <= model_read(address_dmem[7:0]);
                m_k <= m_k + 1;
            end
            if (feed_done && m_feed_active) begin
                m_feed_active <= 1'b0;
                m_done        <= 1'b1;
            end
            // TICKS advances once every PRESCALE cycles since reset or last load.
            if (m_k == W + 1 && is_mmio(address_dmem) && wren && address_dmem[7:0] == 8'h0C) begin
                m_ticks <= data;
                m_since <= 0;
            end else begin
                m_since <= m_since + 1;
                if ((m_since + 1) % PRESCALE == 0) begin
                    m_ticks <= m_ticks + 32'd1;
                    if (m_cmp != 32'd0 && m_ticks + 32'd1 == m_cmp) m_alarm <= 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, half a cycle after the edge.
    always @(negedge clock) begin
        chk("stall", {31'd0, cpuStall},
            {31'd0, reset && is_mmio(address_dmem) && m_k <= W});
        chk("feed_active", {31'd0, feed_active}, {31'd0, m_feed_active});
        chk("feed_amount", {24'd0, feed_amount}, {24'd0, m_feed_amount});
        chk("ram_wren", {31'd0, ram_wren}, {31'd0, wren && is_ram(address_dmem)});
        chk("ram_address", {20'd0, ram_address}, {20'd0, address_dmem[RAM_AW-1:0]});
        if (is_ram(address_dmem))
            chk("q_ram", q_dmem, tb_mem[address_dmem[RAM_AW-1:0]]);
        else if (!is_mmio(address_dmem))
            chk("q_unmapped", q_dmem, 32'd0);
        else if (reset && m_k == W + 1)
            chk("q_mmio", q_dmem, m_rd);
    end

    // ---------------- stimulus ----------------
    // Called just after a rising edge; returns just after the commit edge.
    task automatic access(input logic [31:0] a, input logic [31:0] d, input logic w,
                          output logic [31:0] rd, output int ns);
        logic got;
        got = 1'b0; ns = 0; rd = '0;
        address_dmem = a; data = d; wren = w;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clock);
            if (cpuStall) ns++;
            else begin
                got = 1'b1;
                rd  = q_dmem;
            end
        end
        chk("response_in_bound", {31'd0, got}, 32'd1);
        @(posedge clock); #1;
        address_dmem = IDLE_ADDR; data = '0; wren = 1'b0;
        $display("txn addr=%h wr=%0d wdata=%h rdata=%h stall=%0d", a, w, d, rd, ns);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a,
                          input logic [31:0] exp, input int exp_ns);
        logic [31:0] rd;
        int          ns;
        access(a, 32'd0, 1'b0, rd, ns);
        chk(name, rd, exp);
        chk({name, "_stall_cycles"}, ns, exp_ns);
    endtask

    task automatic wr_chk(input string name, input logic [31:0] a,
                          input logic [31:0] d, input int exp_ns);
        logic [31:0] rd;
        int          ns;
        access(a, d, 1'b1, rd, ns);
        chk({name, "_stall_cycles"}, ns, exp_ns);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; address_dmem = IDLE_ADDR; data = '0; wren = 1'b0;
        feed_done = 1'b0; sensor_level = 12'h3A7;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_stall", {31'd0, cpuStall}, 32'd0);
        chk("reset_feed_active", {31'd0, feed_active}, 32'd0);
        chk("reset_feed_amount", {24'd0, feed_amount}, 32'd0);
        chk("reset_q", q_dmem, 32'd0);
        reset = 1'b1;

        // Timer: CMP=2 committed on edge 4, ALARM lands on edge 8.
        wr_chk("cmp_wr", 32'hFFFF_FF10, 32'd2, W + 1);
        repeat (4) @(posedge clock);
        #1;
        rd_chk("status_alarm", 32'hFFFF_FF00, 32'h8, W + 1);
        rd_chk("status_alarm_cleared", 32'hFFFF_FF00, 32'h0, W + 1);

        // Alarm set on the same edge as the clearing read must survive.
        wr_chk("cmp_wr2", 32'hFFFF_FF10, 32'h100, W + 1);
        wr_chk("ticks_wr", 32'hFFFF_FF0C, 32'hFF, W + 1);
        rd_chk("status_read_at_alarm", 32'hFFFF_FF00, 32'h0, W + 1);
        rd_chk("status_alarm_survives", 32'hFFFF_FF00, 32'h8, W + 1);
        rd_chk("status_alarm_gone", 32'hFFFF_FF00, 32'h0, W + 1);

        // TICKS wraps 0xFFFFFFFF -> 0.
        wr_chk("ticks_wr_max", 32'hFFFF_FF0C, 32'hFFFF_FFFF, W + 1);
        rd_chk("ticks_max", 32'hFFFF_FF0C, 32'hFFFF_FFFF, W + 1);
        rd_chk("ticks_wrapped", 32'hFFFF_FF0C, 32'h0, W + 1);
        rd_chk("cmp_rd", 32'hFFFF_FF10, 32'h100, W + 1);
        wr_chk("cmp_clear", 32'hFFFF_FF10, 32'h0, W + 1);

        // Feed flow.
        wr_chk("feed_wr3", 32'hFFFF_FF04, 32'd3, W + 1);
        chk("feed_active_set", {31'd0, feed_active}, 32'd1);
        chk("feed_amount_3", {24'd0, feed_amount}, 32'd3);
        wr_chk("feed_wr5_busy", 32'hFFFF_FF04, 32'd5, W + 1);
        chk("feed_amount_kept", {24'd0, feed_amount}, 32'd3);
        rd_chk("status_active_err", 32'hFFFF_FF00, 32'h5, W + 1);
        feed_done = 1'b1;
        @(posedge clock); #1;
        feed_done = 1'b0;
        chk("feed_active_cleared", {31'd0, feed_active}, 32'd0);
        rd_chk("status_done", 32'hFFFF_FF00, 32'h2, W + 1);
        rd_chk("status_done_cleared", 32'hFFFF_FF00, 32'h0, W + 1);
        wr_chk("feed_wr0", 32'hFFFF_FF04, 32'd0, W + 1);
        chk("feed_zero_ignored", {31'd0, feed_active}, 32'd0);
        feed_done = 1'b1;
        @(posedge clock); #1;
        feed_done = 1'b0;
        rd_chk("status_idle_done_ignored", 32'hFFFF_FF00, 32'h0, W + 1);

        // Sensor, unmapped, unused MMIO offset.
        rd_chk("sensor", 32'hFFFF_FF08, 32'h0000_03A7, W + 1);
        rd_chk("unmapped_rd", 32'h8000_0000, 32'h0, 0);
        wr_chk("unmapped_wr", 32'h8000_0000, 32'h1234_5678, 0);
        rd_chk("mmio_off20", 32'hFFFF_FF20, 32'h0, W + 1);
        wr_chk("mmio_off20_wr", 32'hFFFF_FF20, 32'hFFFF_FFFF, W + 1);

        // RAM passthrough.
        address_dmem = 32'h0000_0005; data = 32'hDEAD_BEEF; wren = 1'b1;
        @(negedge clock);
        chk("ram_wren_high", {31'd0, ram_wren}, 32'd1);
        chk("ram_address_5", {20'd0, ram_address}, 32'd5);
        chk("ram_no_stall", {31'd0, cpuStall}, 32'd0);
        @(posedge clock); #1;
        wren = 1'b0; data = '0;
        $display("txn addr=%h wr=1 wdata=%h stall=0", 32'h5, 32'hDEAD_BEEF);
        rd_chk("ram_rd", 32'h0000_0005, 32'hDEAD_BEEF, 0);

        // Reset during WAIT of a FEED_CMD write abandons it.
        address_dmem = 32'hFFFF_FF04; data = 32'd7; wren = 1'b1;
        @(posedge clock); #3;
        reset = 1'b0;
        #1;
        chk("reset_mid_stall", {31'd0, cpuStall}, 32'd0);
        address_dmem = IDLE_ADDR; data = '0; wren = 1'b0;
        $display("txn addr=%h wr=1 wdata=%h abandoned by reset", 32'hFFFF_FF04, 32'd7);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        chk("reset_mid_feed_active", {31'd0, feed_active}, 32'd0);
        rd_chk("ticks_after_reset", 32'hFFFF_FF0C, 32'h0, W + 1);
        rd_chk("sensor_after_reset", 32'hFFFF_FF08, 32'h0000_03A7, W + 1);
        chk("feed_active_after_reset", {31'd0, feed_active}, 32'd0);

        repeat (2) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
